// File: rtl/cmplx_mult_pipe.sv
`default_nettype none
// ============================================================================
// cmplx_mult_pipe : 4-stage signed complex multiplier (sample x twiddle) with
//                   optional twiddle conjugation, round-half-up and saturation.
// Revision        : 1.0
// ============================================================================
module cmplx_mult_pipe #(
  parameter int DATA_W = 25,
  parameter int TW_W   = 18,
  parameter int OUT_W  = 25,
  parameter int SHIFT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2*DATA_W-1:0] s_data_i,
  input  logic [2*TW_W-1:0]   s_tw_i,
  input  logic                s_conj_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [2*OUT_W-1:0]  m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                ovf_o,
  input  logic                ovf_clr_i
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 1;
  localparam int RW = SW + 1;
  localparam int CW = ((RW > OUT_W) ? RW : OUT_W) + 1;

  localparam logic signed [RW-1:0] RND     = {{(RW-1){1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Stage registers
  logic                     v1_q, v2_q, v3_q, m_valid_q;
  logic                     conj1_q, conj2_q;
  logic signed [DATA_W-1:0] are1_q, aim1_q;
  logic signed [TW_W-1:0]   wre1_q, wim1_q;
  logic signed [PW-1:0]     prr_q, pii_q, pri_q, pir_q;
  logic signed [SW-1:0]     sre3_q, sim3_q;
  logic [OUT_W-1:0]         mre_q, mim_q;
  logic                     ovf_q;

  // Next-state / combinational values
  logic                     en;
  logic signed [PW-1:0]     are_x, aim_x, wre_x, wim_x;
  logic signed [PW-1:0]     prr_d, pii_d, pri_d, pir_d;
  logic signed [SW-1:0]     prr_x, pii_x, pri_x, pir_x;
  logic signed [SW-1:0]     sre3_d, sim3_d;
  logic signed [RW-1:0]     sre_x, sim_x, rre, rim;
  logic [OUT_W:0]           re_sat, im_sat;
  logic                     ovf_d;

  // Clamp to the output range; MSB of the result flags that clamping happened.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [RW-1:0] r);
    logic signed [CW-1:0] rx;
    rx = {{(CW-RW){r[RW-1]}}, r};
    if (rx > SAT_MAX)      sat_fn = {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (rx < SAT_MIN) sat_fn = {1'b1, SAT_MIN[OUT_W-1:0]};
    else                   sat_fn = {1'b0, rx[OUT_W-1:0]};
  endfunction

  assign en        = m_ready_i | ~m_valid_q;
  assign s_ready_o = en;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = {mre_q, mim_q};
  assign ovf_o     = ovf_q;

  always_comb begin
    are_x = {{TW_W{are1_q[DATA_W-1]}}, are1_q};
    aim_x = {{TW_W{aim1_q[DATA_W-1]}}, aim1_q};
    wre_x = {{DATA_W{wre1_q[TW_W-1]}}, wre1_q};
    wim_x = {{DATA_W{wim1_q[TW_W-1]}}, wim1_q};
    prr_d = are_x * wre_x;
    pii_d = aim_x * wim_x;
    pri_d = are_x * wim_x;
    pir_d = aim_x * wre_x;

    prr_x = {prr_q[PW-1], prr_q};
    pii_x = {pii_q[PW-1], pii_q};
    pri_x = {pri_q[PW-1], pri_q};
    pir_x = {pir_q[PW-1], pir_q};
    // Conjugating the twiddle flips the sign of every w_im term.
    sre3_d = conj2_q ? (prr_x + pii_x) : (prr_x - pii_x);
    sim3_d = conj2_q ? (pir_x - pri_x) : (pri_x + pir_x);

    sre_x  = {sre3_q[SW-1], sre3_q};
    sim_x  = {sim3_q[SW-1], sim3_q};
    rre    = (sre_x + RND) >>> SHIFT;
    rim    = (sim_x + RND) >>> SHIFT;
    re_sat = sat_fn(rre);
    im_sat = sat_fn(rim);

    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (en && v3_q && (re_sat[OUT_W] || im_sat[OUT_W])) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      m_valid_q <= 1'b0;
      conj1_q   <= 1'b0;
      conj2_q   <= 1'b0;
      are1_q    <= '0;
      aim1_q    <= '0;
      wre1_q    <= '0;
      wim1_q    <= '0;
      prr_q     <= '0;
      pii_q     <= '0;
      pri_q     <= '0;
      pir_q     <= '0;
      sre3_q    <= '0;
      sim3_q    <= '0;
      mre_q     <= '0;
      mim_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        v1_q      <= s_valid_i;
        conj1_q   <= s_conj_i;
        are1_q    <= s_data_i[2*DATA_W-1:DATA_W];
        aim1_q    <= s_data_i[DATA_W-1:0];
        wre1_q    <= s_tw_i[2*TW_W-1:TW_W];
        wim1_q    <= s_tw_i[TW_W-1:0];
        v2_q      <= v1_q;
        conj2_q   <= conj1_q;
        prr_q     <= prr_d;
        pii_q     <= pii_d;
        pri_q     <= pri_d;
        pir_q     <= pir_d;
        v3_q      <= v2_q;
        sre3_q    <= sre3_d;
        sim3_q    <= sim3_d;
        m_valid_q <= v3_q;
        mre_q     <= re_sat[OUT_W-1:0];
        mim_q     <= im_sat[OUT_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmplx_mult_pipe.sv
`default_nettype none
// ============================================================================
// tb_cmplx_mult_pipe : vector table, directed corner sequences and a random
//                      stream against an arithmetic reference model.
// Revision           : 1.0
// ============================================================================
module tb_cmplx_mult_pipe;

  localparam int DATA_W = 25;
  localparam int TW_W   = 18;
  localparam int OUT_W  = 25;
  localparam int SHIFT  = 16;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [2*DATA_W-1:0] s_data_i = '0;
  logic [2*TW_W-1:0]   s_tw_i = '0;
  logic                s_conj_i = 1'b0;
  logic                s_valid_i = 1'b0;
  logic                s_ready_o;
  logic [2*OUT_W-1:0]  m_data_o;
  logic                m_valid_o;
  logic                m_ready_i = 1'b1;
  logic                ovf_o;
  logic                ovf_clr_i = 1'b0;

  cmplx_mult_pipe #(.DATA_W(DATA_W), .TW_W(TW_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_data_i(s_data_i), .s_tw_i(s_tw_i), .s_conj_i(s_conj_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint are, aim, wre, wim;
    bit     conj;
    longint ere, eim;
    bit     eovf;
  } vec_t;

  typedef struct {
    longint re, im;
    bit     sat;
  } exp_t;

  int     n_vec = 0;
  int     n_err = 0;
  bit     any_sat;
  exp_t   exp_q[$];
  vec_t   src[$];
  vec_t   tbl[9];

  // Mathematical reference: exact product, round half up, clamp.
  function automatic exp_t model(input vec_t v);
    exp_t   m;
    longint sr, si, rr, ri, lim;
    lim = 64'sd1 <<< (OUT_W-1);
    if (!v.conj) begin
      sr = v.are*v.wre - v.aim*v.wim;
      si = v.are*v.wim + v.aim*v.wre;
    end else begin
      sr = v.are*v.wre + v.aim*v.wim;
      si = v.aim*v.wre - v.are*v.wim;
    end
    rr = (sr + (64'sd1 <<< (SHIFT-1))) >>> SHIFT;
    ri = (si + (64'sd1 <<< (SHIFT-1))) >>> SHIFT;
    m.sat = 1'b0;
    if (rr > lim-1) begin rr = lim-1; m.sat = 1'b1; end
    if (rr < -lim)  begin rr = -lim;  m.sat = 1'b1; end
    if (ri > lim-1) begin ri = lim-1; m.sat = 1'b1; end
    if (ri < -lim)  begin ri = -lim;  m.sat = 1'b1; end
    m.re = rr;
    m.im = ri;
    return m;
  endfunction

  function automatic longint rnd_s(input int w);
    longint x;
    x = longint'($urandom) & ((64'sd1 <<< w) - 1);
    if (x >= (64'sd1 <<< (w-1))) x = x - (64'sd1 <<< w);
    return x;
  endfunction

  function automatic longint out_re();
    logic signed [OUT_W-1:0] t;
    t = m_data_o[2*OUT_W-1:OUT_W];
    return longint'(t);
  endfunction

  function automatic longint out_im();
    logic signed [OUT_W-1:0] t;
    t = m_data_o[OUT_W-1:0];
    return longint'(t);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input vec_t v);
    s_data_i  = {DATA_W'(v.are), DATA_W'(v.aim)};
    s_tw_i    = {TW_W'(v.wre), TW_W'(v.wim)};
    s_conj_i  = v.conj;
    s_valid_i = 1'b1;
  endtask

  // Single beat on an empty pipe; optionally clears the sticky flag first.
  task automatic run_one(input vec_t v, input string nm, input bit do_clr, input bit exp_ovf);
    int k;
    if (do_clr) begin
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
    end
    drive(v);
    tick();
    s_valid_i = 1'b0;
    k = 0;
    while (!m_valid_o && k < 10) begin
      tick();
      k++;
    end
    if (!m_valid_o) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_re"}, out_re(), v.ere);
      chk({nm, "_im"}, out_im(), v.eim);
      chk({nm, "_ovf"}, longint'(ovf_o), longint'(exp_ovf));
    end
    tick();
  endtask

  // Identity beat checking exact 4-cycle latency.
  task automatic lat_check(input string nm);
    drive(tbl[0]);
    for (int k = 1; k <= 4; k++) begin
      tick();
      s_valid_i = 1'b0;
      if (k < 4) chk({nm, "_early_valid"}, longint'(m_valid_o), 0);
    end
    chk({nm, "_valid"}, longint'(m_valid_o), 1);
    chk({nm, "_re"}, out_re(), 1000);
    chk({nm, "_im"}, out_im(), -2000);
    tick();
  endtask

  // mode 0: fixed stall in cycles 5..9; mode 1: random valid/ready.
  task automatic stream(input int mode, input string nm);
    int                 cyc, idx, got, n;
    bit                 prev_stall;
    logic [2*OUT_W-1:0] prev_d;
    exp_t               e;
    cyc = 0; idx = 0; got = 0; n = src.size();
    prev_stall = 1'b0;
    prev_d = '0;
    while ((idx < n || exp_q.size() > 0) && cyc < 5000) begin
      m_ready_i = (mode == 0) ? !(cyc >= 5 && cyc <= 9) : ($urandom_range(0, 3) != 0);
      if (idx < n && (mode == 0 || s_valid_i || $urandom_range(0, 3) != 0)) drive(src[idx]);
      else s_valid_i = 1'b0;
      @(negedge clk_i);
      if (mode == 0 && !m_ready_i && m_valid_o) begin
        chk({nm, "_stall_s_ready"}, longint'(s_ready_o), 0);
        if (prev_stall) chk({nm, "_stall_hold"}, longint'(m_data_o), longint'(prev_d));
      end
      prev_stall = !m_ready_i && m_valid_o;
      prev_d     = m_data_o;
      if (s_valid_i && s_ready_o) begin
        e = model(src[idx]);
        exp_q.push_back(e);
        any_sat |= e.sat;
        idx++;
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_extra_beat"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({nm, "_re"}, out_re(), e.re);
          chk({nm, "_im"}, out_im(), e.im);
          got++;
        end
      end
      tick();
      cyc++;
    end
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    chk({nm, "_drained"}, longint'(exp_q.size()), 0);
    chk({nm, "_count"}, got, n);
    exp_q.delete();
    src.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    bit   stale;
    tbl[0] = '{1000, -2000, 65536, 0, 1'b0, 1000, -2000, 1'b0};
    tbl[1] = '{1000, 2000, 0, 65536, 1'b0, -2000, 1000, 1'b0};
    tbl[2] = '{1000, 2000, 0, 65536, 1'b1, 2000, -1000, 1'b0};
    tbl[3] = '{3, -3, 32768, 0, 1'b0, 2, -1, 1'b0};
    tbl[4] = '{16777215, -16777216, 131071, 0, 1'b0, 16777215, -16777216, 1'b1};
    tbl[5] = '{-16777216, 0, -131072, 0, 1'b0, 16777215, 0, 1'b1};
    tbl[6] = '{0, 16777215, 0, 131071, 1'b1, 16777215, 0, 1'b1};
    tbl[7] = '{100, -50, -65536, 65536, 1'b1, -150, -50, 1'b0};
    tbl[8] = '{-1, 0, 32768, 0, 1'b0, 0, 0, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_m_valid", longint'(m_valid_o), 0);
    chk("rst_ovf", longint'(ovf_o), 0);
    chk("rst_m_data", longint'(m_data_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    lat_check("latency");

    for (int i = 0; i < 9; i++) begin
      run_one(tbl[i], $sformatf("tbl%0d", i), 1'b1, tbl[i].eovf);
    end

    // Rotation then conjugated rotation on consecutive output cycles
    drive(tbl[1]);
    tick();
    drive(tbl[2]);
    tick();
    s_valid_i = 1'b0;
    tick();
    tick();
    chk("rot_c0_valid", longint'(m_valid_o), 1);
    chk("rot_c0_re", out_re(), -2000);
    chk("rot_c0_im", out_im(), 1000);
    tick();
    chk("rot_c1_valid", longint'(m_valid_o), 1);
    chk("rot_c1_re", out_re(), 2000);
    chk("rot_c1_im", out_im(), -1000);
    tick();

    // Sticky overflow, clear, and clear coincident with a new overflow
    run_one(tbl[4], "sticky_set", 1'b1, 1'b1);
    run_one(tbl[0], "sticky_hold", 1'b0, 1'b1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("ovf_clear", longint'(ovf_o), 0);
    drive(tbl[4]);
    ovf_clr_i = 1'b1;
    tick();
    s_valid_i = 1'b0;
    tick();
    tick();
    tick();
    chk("clr_vs_set_valid", longint'(m_valid_o), 1);
    chk("clr_vs_set_ovf", longint'(ovf_o), 1);
    ovf_clr_i = 1'b0;
    tick();
    chk("clr_vs_set_after", longint'(ovf_o), 1);

    // Backpressure stream: values 1..8 through the identity twiddle
    for (int k = 1; k <= 8; k++) begin
      v = '{k, -k, 65536, 0, 1'b0, 0, 0, 1'b0};
      src.push_back(v);
    end
    stream(0, "bp");

    // Reset mid-stream (ovf is still set from the coincident test)
    for (int k = 0; k < 5; k++) begin
      v = '{k + 10, k, 65536, 0, 1'b0, 0, 0, 1'b0};
      drive(v);
      tick();
    end
    s_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_m_valid", longint'(m_valid_o), 0);
    chk("midrst_ovf", longint'(ovf_o), 0);
    chk("midrst_m_data", longint'(m_data_o), 0);
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (m_valid_o) stale = 1'b1;
    end
    chk("midrst_no_stale", longint'(stale), 0);
    lat_check("post_rst");

    // Random stream against the reference model
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    any_sat = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        v.are = rnd_s(DATA_W);
        v.aim = rnd_s(DATA_W);
      end else begin
        v.are = longint'(int'($urandom_range(0, 2000)) - 1000);
        v.aim = longint'(int'($urandom_range(0, 2000)) - 1000);
      end
      v.wre  = rnd_s(TW_W);
      v.wim  = rnd_s(TW_W);
      v.conj = $urandom_range(0, 1) != 0;
      v.ere  = 0;
      v.eim  = 0;
      v.eovf = 1'b0;
      src.push_back(v);
    end
    stream(1, "rand");
    chk("rand_ovf", longint'(ovf_o), longint'(any_sat));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
